// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the VC0/VC1 weighted round-robin arbiter:
// FSM state encoding, weight width, default data width, weight helper.
package vc_arbiter_pkg;

    localparam int WEIGHT_W  = 4;
    localparam int DEF_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    // A programmed weight of zero still grants one pop per turn.
    function automatic logic [WEIGHT_W-1:0] eff_weight(
        input logic [WEIGHT_W-1:0] w
    );
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

endpackage

// File: rtl/vc_arbiter_out_reg.sv
// Output stage: registers the push strobe and source VC of each pop.
// Ports: clk, reset_L, capture (pop this cycle), sel (popped VC),
//        data0/data1 (source read data, valid the cycle after a pop),
//        push, data, vc (downstream push, word, VC tag).
module vc_arbiter_out_reg
    import vc_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             capture,
    input  logic             sel,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             push,
    output logic [WIDTH-1:0] data,
    output logic             vc
);

    logic [WIDTH-1:0] hold;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push <= 1'b0;
            vc   <= 1'b0;
            hold <= '0;
        end else begin
            push <= capture;
            if (capture) vc <= sel;
            if (push) hold <= data;
        end
    end

    // Source read data only becomes valid in the push cycle, so the word
    // is steered straight through then and held afterwards.
    assign data = push ? (vc ? data1 : data0) : hold;

endmodule

// File: rtl/vc_arbiter.sv
// Weighted round-robin drain of VC0/VC1 source FIFOs into one dest FIFO.
// Ports: clk, reset_L, active, vcX_empty/data/weight, dest_full in;
//        vcX_pop, dest_push, dest_data, dest_vc, arb_idle out.
// Macro VC_ARBITER_STATS_EN adds 8-bit vc0_grants/vc1_grants counters.
module vc_arbiter
    import vc_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                active,
    input  logic                vc0_empty,
    input  logic                vc1_empty,
    input  logic [WIDTH-1:0]    vc0_data,
    input  logic [WIDTH-1:0]    vc1_data,
    input  logic [WEIGHT_W-1:0] vc0_weight,
    input  logic [WEIGHT_W-1:0] vc1_weight,
    input  logic                dest_full,
    output logic                vc0_pop,
    output logic                vc1_pop,
    output logic                dest_push,
    output logic [WIDTH-1:0]    dest_data,
    output logic                dest_vc,
    output logic                arb_idle
`ifdef VC_ARBITER_STATS_EN
    ,
    output logic [7:0]          vc0_grants,
    output logic [7:0]          vc1_grants
`endif
);

    state_t              state, state_n;
    logic                last_vc, last_vc_n;
    logic [WEIGHT_W-1:0] cnt, cnt_n;
    logic [WEIGHT_W-1:0] limit, limit_n;
    logic [WEIGHT_W-1:0] cnt_inc;
    logic                cur_vc, cur_empty, oth_empty;
    logic                pop, tgt;

    assign cur_vc    = (state == SERVE1);
    assign cur_empty = cur_vc ? vc1_empty : vc0_empty;
    assign oth_empty = cur_vc ? vc0_empty : vc1_empty;
    assign cnt_inc   = cnt + WEIGHT_W'(1);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state   <= IDLE;
            last_vc <= 1'b1;
            cnt     <= '0;
            limit   <= '0;
        end else begin
            state   <= state_n;
            last_vc <= last_vc_n;
            cnt     <= cnt_n;
            limit   <= limit_n;
        end
    end

    always_comb begin
        state_n   = state;
        last_vc_n = last_vc;
        cnt_n     = cnt;
        limit_n   = limit;
        pop       = 1'b0;
        tgt       = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (active && !(vc0_empty && vc1_empty)) begin
                    // Alternate when both wait, else take the busy one.
                    tgt     = vc0_empty ? 1'b1 :
                              vc1_empty ? 1'b0 : !last_vc;
                    state_n = tgt ? SERVE1 : SERVE0;
                    limit_n = eff_weight(tgt ? vc1_weight : vc0_weight);
                end
            end
            SERVE0, SERVE1: begin
                if (!active) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    last_vc_n = cur_vc;
                end else if (!dest_full) begin
                    pop = !cur_empty;
                    if (pop && cnt_inc != limit) begin
                        cnt_n = cnt_inc;
                    end else begin
                        cnt_n = '0;
                        if (!oth_empty) begin
                            state_n   = cur_vc ? SERVE0 : SERVE1;
                            limit_n   = eff_weight(cur_vc ? vc0_weight
                                                          : vc1_weight);
                            last_vc_n = cur_vc;
                        end else if (!cur_empty) begin
                            limit_n = eff_weight(cur_vc ? vc1_weight
                                                        : vc0_weight);
                        end else begin
                            state_n   = IDLE;
                            last_vc_n = cur_vc;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign vc0_pop  = pop & !cur_vc;
    assign vc1_pop  = pop & cur_vc;
    assign arb_idle = (state == IDLE) && !dest_push;

    vc_arbiter_out_reg #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk     (clk),
        .reset_L (reset_L),
        .capture (pop),
        .sel     (cur_vc),
        .data0   (vc0_data),
        .data1   (vc1_data),
        .push    (dest_push),
        .data    (dest_data),
        .vc      (dest_vc)
    );

`ifdef VC_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            vc0_grants <= 8'd0;
            vc1_grants <= 8'd0;
        end else begin
            if (vc0_pop) vc0_grants <= vc0_grants + 8'd1;
            if (vc1_pop) vc1_grants <= vc1_grants + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// Randomised/directed bench for vc_arbiter with source FIFO model,
// push scoreboard and weighted-sequence reference.
module tb_vc_arbiter;

    localparam int W = 6;

    logic         clk;
    logic         reset_L;
    logic         active;
    logic         vc0_empty, vc1_empty;
    logic [W-1:0] vc0_data, vc1_data;
    logic [3:0]   vc0_weight, vc1_weight;
    logic         dest_full;
    logic         vc0_pop, vc1_pop;
    logic         dest_push;
    logic [W-1:0] dest_data;
    logic         dest_vc;
    logic         arb_idle;
`ifdef VC_ARBITER_STATS_EN
    logic [7:0]   vc0_grants, vc1_grants;
`endif

    vc_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .active     (active),
        .vc0_empty  (vc0_empty),
        .vc1_empty  (vc1_empty),
        .vc0_data   (vc0_data),
        .vc1_data   (vc1_data),
        .vc0_weight (vc0_weight),
        .vc1_weight (vc1_weight),
        .dest_full  (dest_full),
        .vc0_pop    (vc0_pop),
        .vc1_pop    (vc1_pop),
        .dest_push  (dest_push),
        .dest_data  (dest_data),
        .dest_vc    (dest_vc),
        .arb_idle   (arb_idle)
`ifdef VC_ARBITER_STATS_EN
        ,
        .vc0_grants (vc0_grants),
        .vc1_grants (vc1_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W:0]   exp_q[$];
    int           fill0 = 0;
    int           fill1 = 0;
    logic         cur_pop0 = 1'b0;
    logic         cur_pop1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name,
                     $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        return W'($urandom);
    endfunction

    function automatic int pv();
        return cur_pop0 ? 0 : (cur_pop1 ? 1 : -1);
    endfunction

    // One clock: source FIFOs act on last cycle's pops, then new inputs.
    task automatic step(input logic r, input logic a, input logic f);
        logic [W-1:0] d;
        @(negedge clk);
        reset_L = r;
        if (cur_pop0) begin
            d = (q0.size() != 0) ? q0.pop_front() : '0;
            vc0_data = d;
            if (reset_L) exp_q.push_back({1'b0, d});
        end
        if (cur_pop1) begin
            d = (q1.size() != 0) ? q1.pop_front() : '0;
            vc1_data = d;
            if (reset_L) exp_q.push_back({1'b1, d});
        end
        if (fill0 == 1) while (q0.size() < 4) q0.push_back(rnd_word());
        if (fill1 == 1) while (q1.size() < 4) q1.push_back(rnd_word());
        if (fill0 == 2 && q0.size() < 8 && $urandom_range(0, 2) == 0)
            q0.push_back(rnd_word());
        if (fill1 == 2 && q1.size() < 8 && $urandom_range(0, 2) == 0)
            q1.push_back(rnd_word());
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        active    = a;
        dest_full = f;
        #1;
        cur_pop0 = vc0_pop;
        cur_pop1 = vc1_pop;
    endtask

    // Monitor: pushes against scoreboard, pop legality, no long stalls.
    logic [W:0] e;
    int         stall = 0;
    logic       elig;
    always @(negedge clk) begin
        #3;
        chk("pop_excl", vc0_pop & vc1_pop, 0);
        chk("pop0_legal", vc0_pop & !(active & !dest_full & !vc0_empty), 0);
        chk("pop1_legal", vc1_pop & !(active & !dest_full & !vc1_empty), 0);
        chk("push", dest_push, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (dest_push) begin
                chk("dest_data", dest_data, e[W-1:0]);
                chk("dest_vc", dest_vc, e[W]);
            end
        end
        elig = reset_L & active & !dest_full & !(vc0_empty & vc1_empty);
        stall = (elig && !vc0_pop && !vc1_pop) ? stall + 1 : 0;
        chk("stall", stall > 2, 0);
    end

    function automatic int serv44(input int k);
        return ((k / 4) % 2 == 0) ? 1 : 0;
    endfunction

    initial begin
        int first, n1, cnt, nlog, v, ex, pp, p2, x;
        int p0a[16];
        int ida[16];
        reset_L = 1'b0; active = 1'b0; dest_full = 1'b0;
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        vc0_data = '0; vc1_data = '0;
        vc0_weight = 4'd3; vc1_weight = 4'd1;

        // Reset held with traffic present, then release.
        fill0 = 1; fill1 = 1;
        repeat (3) begin
            step(1'b0, 1'b1, 1'b0);
            chk("rst_pop0", cur_pop0, 0);
            chk("rst_pop1", cur_pop1, 0);
            chk("rst_push", dest_push, 0);
            chk("rst_idle", arb_idle, 1);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("rel_bubble", pv(), -1);

        // Weights 3/1 saturated: 0,0,0,1 repeating, starting on VC0.
        for (int c = 0; c < 24; c++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("wrr_seq", pv(), ((c % 4) < 3) ? 0 : 1);
        end

        // Drain five words from VC0 alone, weight 2.
        fill0 = 0; fill1 = 0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        q0.delete(); q1.delete();
        repeat (5) q0.push_back(rnd_word());
        vc0_weight = 4'd2;
        first = -1; n1 = 0;
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 1'b1, 1'b0);
            p0a[c] = int'(cur_pop0);
            ida[c] = int'(arb_idle);
            n1 += int'(cur_pop1);
            if (cur_pop0 && first < 0) first = c;
        end
        chk("drain_vc1", n1, 0);
        chk("drain_start", first >= 0 && first < 9, 1);
        if (first >= 0 && first < 9) begin
            cnt = 0;
            for (int i = 0; i < 5; i++) cnt += p0a[first+i];
            chk("drain_run", cnt, 5);
            cnt = 0;
            for (int i = 0; i < 16; i++) cnt += p0a[i];
            chk("drain_total", cnt, 5);
            chk("drain_busy", ida[first+5], 0);
            chk("drain_idle", ida[first+6], 1);
        end

        // Weights 4/4, dest_full for 3 cycles after 2 pops; VC1 first.
        fill0 = 1; fill1 = 1;
        vc0_weight = 4'd4; vc1_weight = 4'd4;
        nlog = 0;
        for (int c = 0; c < 40 && nlog < 16; c++) begin
            step(1'b1, 1'b1, nlog >= 2 && nlog < 5);
            v = pv();
            if (nlog > 0 || v >= 0) begin
                ex = (nlog < 2) ? serv44(nlog) :
                     (nlog < 5) ? -1 : serv44(nlog - 3);
                chk("full_seq", v, ex);
                if (nlog == 2) chk("full_push", dest_push, 1);
                nlog++;
            end
        end
        chk("full_len", nlog, 16);

        // Drop active for one cycle on the second pop of a turn.
        pp = -1; p2 = -1; x = -1;
        for (int c = 0; c < 20 && x < 0; c++) begin
            step(1'b1, 1'b1, 1'b0);
            v = pv();
            if (v >= 0 && v == pp && p2 >= 0 && p2 != pp) x = v;
            p2 = pp; pp = v;
        end
        chk("act_found", x >= 0, 1);
        if (x >= 0) begin
            step(1'b1, 1'b0, 1'b0);
            chk("act_drop", pv(), -1);
            step(1'b1, 1'b1, 1'b0);
            chk("act_bubble", pv(), -1);
            chk("act_idle", arb_idle, 1);
            step(1'b1, 1'b1, 1'b0);
            chk("act_resume", pv(), 1 - x);
        end

        // Reset in the cycle after a pop: the word is discarded.
        for (int c = 0; c < 6 && pv() < 0; c++) step(1'b1, 1'b1, 1'b0);
        chk("rst_pre_pop", pv() >= 0, 1);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_nopush", dest_push, 0);
        chk("rst_idle2", arb_idle, 1);
`ifdef VC_ARBITER_STATS_EN
        chk("rst_g0", vc0_grants, 0);
        chk("rst_g1", vc1_grants, 0);
        fill1 = 0; q1.delete();
        cnt = 0;
        for (int c = 0; c < 400 && cnt < 256; c++) begin
            step(1'b1, 1'b1, 1'b0);
            if (cur_pop0) cnt++;
            if (cnt == 128 && cur_pop0) begin
                step(1'b1, 1'b1, 1'b0);
                chk("g0_half", vc0_grants, 128);
                if (cur_pop0) cnt++;
            end
        end
        chk("g0_pops", cnt, 256);
        step(1'b1, 1'b1, 1'b0);
        chk("g0_wrap", vc0_grants, 0);
        chk("g1_zero", vc1_grants, 0);
`endif
        step(1'b1, 1'b1, 1'b0);

        // Random traffic, gating and weights.
        fill0 = 2; fill1 = 2;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                vc0_weight = 4'($urandom_range(0, 15));
                vc1_weight = 4'($urandom_range(0, 15));
            end
            step(1'b1, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0);
        end

        fill0 = 0; fill1 = 0;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
